// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side controllers: FSM state encoding
// and width helpers used to size counters and index ports.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Index width that stays at least one bit even for a single entry.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Beat counter must be able to hold BURST_LEN itself.
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo N. Returns both one-hot and binary index of the winner.
module rr_select
  import fifo_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest match wins last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N]) begin
        onehot = '0;
        onehot[(int'(rr_ptr) + k) % N] = 1'b1;
        idx = IW'((int'(rr_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO write port. A grant is only
// issued when the FIFO has room for a full burst; a one-cycle gap follows each burst.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 16,
  parameter int SPACE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ-1:0]            s_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_full,
  input  logic [SPACE_WIDTH-1:0]        fifo_space,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          busy,
  output logic [cnt_width(BURST_LEN)-1:0] beat_cnt
);

  localparam int IW = clog2w(NUM_REQ);
  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [IW-1:0]        sel_idx;
  logic                 in_burst, space_ok, accept, last_beat;
  logic [CW-1:0]        cnt_inc;

  rr_select #(.N(NUM_REQ), .IW(IW)) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .onehot (sel_onehot),
    .idx    (sel_idx)
  );

  assign in_burst  = (state_q == ST_BURST);
  assign space_ok  = int'(fifo_space) >= BURST_LEN;
  assign accept    = in_burst & s_valid[idx_q] & ~fifo_full;
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_beat = s_last[idx_q] | (cnt_inc == BURST_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req && space_ok) begin
          state_d  = ST_BURST;
          grant_d  = sel_onehot;
          idx_d    = sel_idx;
          rr_ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
          cnt_d    = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (last_beat) begin
            state_d = ST_GAP;
            grant_d = '0;
          end
        end else if (!req[idx_q]) begin
          // Owner withdrew without a beat: close the burst, keep what was written.
          state_d = ST_GAP;
          grant_d = '0;
        end
      end
      ST_GAP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    busy       = in_burst;
    grant      = grant_q;
    beat_cnt   = cnt_q;
    s_ready    = in_burst ? (grant_q & {NUM_REQ{~fifo_full}}) : '0;
    fifo_wr_en = accept;
    fifo_din   = in_burst ? s_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus
// hand-written multi-cycle sequences (rotation, stall, reset, abort).
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 16;
  localparam int SW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req, s_valid, s_last, s_ready, grant;
  logic [N*DW-1:0] s_data;
  logic          fifo_full, fifo_wr_en, busy;
  logic [SW-1:0] fifo_space;
  logic [DW-1:0] fifo_din;
  logic [CW-1:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .SPACE_WIDTH(SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .grant      (grant),
    .fifo_full  (fifo_full),
    .fifo_space (fifo_space),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
  );

  typedef struct {
    logic [3:0] req, val, last;
    logic       full;
    logic [7:0] space, d;
    logic [3:0] grant, rdy;
    logic       busy, wr;
    logic [7:0] din;
    logic [4:0] cnt;
  } vec_t;

  vec_t tv[20];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] v,
                              input logic [3:0] l, input logic f,
                              input logic [7:0] sp, input logic [7:0] dd,
                              input logic [3:0] g, input logic [3:0] rd,
                              input logic b, input logic w,
                              input logic [7:0] dn, input logic [4:0] c);
    vec_t t;
    t.req = r; t.val = v; t.last = l; t.full = f; t.space = sp; t.d = dd;
    t.grant = g; t.rdy = rd; t.busy = b; t.wr = w; t.din = dn; t.cnt = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; s_valid = '0; s_last = '0; s_data = '0;
    fifo_full = 1'b0; fifo_space = 8'd128;
    @(negedge clk);
    #1;
    check("reset grant", grant, 0);
    check("reset busy", busy, 0);
    check("reset beat_cnt", beat_cnt, 0);
    check("reset wr_en", fifo_wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int order[5];
  int writes, acc, stalls, cyc;
  logic [7:0] dval;

  initial begin
    // req, val, last, full, space, d | grant, rdy, busy, wr, din, cnt
    tv[0]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 8'd128, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd0);
    tv[1]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 8'd128, 8'h01, 4'b0100, 4'b0100, 1, 1, 8'h21, 5'd0);
    tv[2]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 8'd128, 8'h02, 4'b0100, 4'b0100, 1, 1, 8'h22, 5'd1);
    tv[3]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 8'd128, 8'h03, 4'b0100, 4'b0100, 1, 1, 8'h23, 5'd2);
    tv[4]  = mk(4'b0100, 4'b0100, 4'b0000, 0, 8'd128, 8'h04, 4'b0100, 4'b0100, 1, 1, 8'h24, 5'd3);
    tv[5]  = mk(4'b0100, 4'b0100, 4'b0100, 0, 8'd128, 8'h05, 4'b0100, 4'b0100, 1, 1, 8'h25, 5'd4);
    tv[6]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 8'd128, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd5);
    tv[7]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 8'd128, 8'h55, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd5);
    tv[8]  = mk(4'b1111, 4'b1011, 4'b0000, 0, 8'd128, 8'h09, 4'b0100, 4'b0100, 1, 0, 8'h29, 5'd0);
    tv[9]  = mk(4'b1011, 4'b1011, 4'b0000, 0, 8'd128, 8'h0A, 4'b0100, 4'b0100, 1, 0, 8'h2A, 5'd0);
    tv[10] = mk(4'b1011, 4'b0000, 4'b0000, 0, 8'd128, 8'h66, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd0);
    tv[11] = mk(4'b1011, 4'b0000, 4'b0000, 0, 8'd128, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd0);
    tv[12] = mk(4'b1011, 4'b1000, 4'b1000, 1, 8'd128, 8'h07, 4'b1000, 4'b0000, 1, 0, 8'h37, 5'd0);
    tv[13] = mk(4'b1011, 4'b1000, 4'b1000, 0, 8'd128, 8'h07, 4'b1000, 4'b1000, 1, 1, 8'h37, 5'd0);
    tv[14] = mk(4'b0000, 4'b0000, 4'b0000, 0, 8'd128, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd1);
    tv[15] = mk(4'b0000, 4'b0000, 4'b0000, 0, 8'd128, 8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd1);
    tv[16] = mk(4'b0001, 4'b0000, 4'b0000, 0, 8'd15,  8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd1);
    tv[17] = mk(4'b0001, 4'b0000, 4'b0000, 0, 8'd15,  8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd1);
    tv[18] = mk(4'b0001, 4'b0000, 4'b0000, 0, 8'd16,  8'h00, 4'b0000, 4'b0000, 0, 0, 8'h00, 5'd1);
    tv[19] = mk(4'b0001, 4'b0000, 4'b0000, 0, 8'd16,  8'h11, 4'b0001, 4'b0001, 1, 0, 8'h11, 5'd0);

    // ---- per-cycle vector table ----
    do_reset();
    for (int i = 0; i < 20; i++) begin
      req = tv[i].req; s_valid = tv[i].val; s_last = tv[i].last;
      fifo_full = tv[i].full; fifo_space = tv[i].space;
      s_data = {4{tv[i].d}} ^ 32'h30201000;
      #1;
      check($sformatf("vec%0d grant", i), grant, tv[i].grant);
      check($sformatf("vec%0d s_ready", i), s_ready, tv[i].rdy);
      check($sformatf("vec%0d busy", i), busy, tv[i].busy);
      check($sformatf("vec%0d wr_en", i), fifo_wr_en, tv[i].wr);
      check($sformatf("vec%0d din", i), fifo_din, tv[i].din);
      check($sformatf("vec%0d beat_cnt", i), beat_cnt, tv[i].cnt);
      $display("vec %0d: req=%b grant=%b ready=%b busy=%b wr=%b din=%h cnt=%0d",
               i, req, grant, s_ready, busy, fifo_wr_en, fifo_din, beat_cnt);
      tick();
    end

    // ---- full rotation, all requesters streaming ----
    do_reset();
    req = 4'b1111; s_valid = 4'b1111; s_last = '0; s_data = 32'h44332211;
    order = '{0, 1, 2, 3, 0};
    for (int b = 0; b < 5; b++) begin
      #1;
      check("rot idle busy", busy, 0);
      check("rot idle grant", grant, 0);
      tick();
      check("rot grant", grant, 4'b0001 << order[b]);
      writes = 0;
      for (int c = 0; c < BL; c++) begin
        #1;
        writes += int'(fifo_wr_en);
        tick();
      end
      check("rot writes", writes, BL);
      check("rot gap grant", grant, 0);
      check("rot gap busy", busy, 0);
      check("rot gap beat_cnt", beat_cnt, BL);
      $display("burst %0d: grant idx %0d writes=%0d", b, order[b], writes);
      tick();
    end

    // ---- FIFO full for 3 cycles at beat 8 ----
    do_reset();
    req = 4'b0010; s_valid = 4'b0010; s_data = {4{8'h40}};
    tick();
    check("stall grant", grant, 4'b0010);
    acc = 0; stalls = 0; cyc = 0;
    while (busy && cyc < 60) begin
      fifo_full = (acc == 8 && stalls < 3);
      dval = 8'h40 + 8'(acc);
      s_data = {4{dval}};
      #1;
      check("stall din", fifo_din, dval);
      check("stall wr_en", fifo_wr_en, !fifo_full);
      if (fifo_full) begin
        check("stall beat_cnt", beat_cnt, 8);
        check("stall grant held", grant, 4'b0010);
        stalls++;
      end
      if (fifo_wr_en) acc++;
      tick();
      cyc++;
    end
    fifo_full = 1'b0;
    check("stall total writes", acc, BL);
    check("stall cycles", stalls, 3);
    check("stall end beat_cnt", beat_cnt, BL);
    check("stall end busy", busy, 0);
    $display("stall burst: writes=%0d stalls=%0d cycles=%0d", acc, stalls, cyc);

    // ---- reset in the middle of a burst ----
    do_reset();
    req = 4'b0010; s_valid = 4'b0010; s_data = {4{8'h5A}};
    tick();
    for (int k = 0; k < 10; k++) tick();
    #1;
    check("mid-reset beat_cnt before", beat_cnt, 10);
    rst = 1'b1;
    #1;
    check("mid-reset wr_en", fifo_wr_en, 0);
    check("mid-reset grant", grant, 0);
    check("mid-reset busy", busy, 0);
    check("mid-reset beat_cnt", beat_cnt, 0);
    check("mid-reset s_ready", s_ready, 0);
    tick();
    req = 4'b0011; rst = 1'b0;
    #1;
    check("post-reset idle grant", grant, 0);
    tick();
    check("post-reset grant", grant, 4'b0001);
    $display("reset mid-burst: next grant=%b", grant);

    // ---- owner drops req at beat 4 ----
    do_reset();
    req = 4'b0001; s_valid = 4'b0001; s_data = {4{8'h77}};
    tick();
    check("abort grant", grant, 4'b0001);
    for (int k = 0; k < 4; k++) tick();
    s_valid = '0; req = 4'b0010;
    #1;
    check("abort wr_en", fifo_wr_en, 0);
    check("abort beat_cnt", beat_cnt, 4);
    tick();
    check("abort gap busy", busy, 0);
    check("abort gap grant", grant, 0);
    check("abort gap beat_cnt", beat_cnt, 4);
    req = 4'b0011;
    tick();
    check("abort idle grant", grant, 0);
    tick();
    check("abort next grant", grant, 4'b0010);
    $display("abort: next grant=%b", grant);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, beat width, equal to the FIFO write width.
REQ-003 SHALL have parameter BURST_LEN, default 16, maximum beats per grant (power of two, >=2).
REQ-004 SHALL have parameter SPACE_WIDTH, default 8, width of the FIFO free-space input (clog2(WR_DEPTH)+1).
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous active-high reset
  req  in  NUM_REQ  per-requester burst request, level
  s_valid  in  NUM_REQ  per-requester beat valid
  s_last  in  NUM_REQ  per-requester final beat marker
  s_data  in  NUM_REQ*DATA_WIDTH  requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
  s_ready  out  NUM_REQ  per-requester beat accept
  grant  out  NUM_REQ  one-hot current owner, zero when idle
  fifo_full  in  1  FIFO full flag (write domain)
  fifo_space  in  SPACE_WIDTH  FIFO free entries (write domain)
  fifo_wr_en  out  1  FIFO write enable
  fifo_din  out  DATA_WIDTH  FIFO write data
  busy  out  1  high in BURST state
  beat_cnt  out  clog2(BURST_LEN)+1  beats accepted in current burst

Function
REQ-007 SHALL implement FSM states IDLE, BURST, GAP; the state register resets to IDLE.
REQ-008 IDLE -> BURST on the next edge when any req is high and fifo_space >= BURST_LEN; otherwise it SHALL remain in IDLE.
REQ-009 The IDLE->BURST transition SHALL register grant as one-hot of the first requesting index searched upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-010 On the same transition, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; rr_ptr resets to 0.
REQ-011 In BURST, s_ready[g] SHALL equal !fifo_full for the granted index g; all other s_ready bits SHALL be 0; in IDLE/GAP all s_ready bits SHALL be 0.
REQ-012 fifo_wr_en SHALL be combinational: busy & s_valid[g] & s_ready[g]; this gives zero-cycle latency from beat to FIFO write.
REQ-013 fifo_din SHALL be combinational: s_data slice of g while busy, else all zero.
REQ-014 beat_cnt SHALL increment by 1 on each accepted beat, clear to 0 on entry to BURST, and never exceed BURST_LEN.
REQ-015 BURST -> GAP SHALL occur on an accepted beat that has s_last[g]=1 or that brings beat_cnt to BURST_LEN.
REQ-016 BURST -> GAP SHALL also occur when req[g] is low and no beat is accepted in that cycle (abort); the beats already written SHALL stand.
REQ-017 GAP SHALL last exactly one cycle with grant=0, then return to IDLE, so fifo_space is re-sampled before the next grant.
REQ-018 When fifo_full is asserted mid-burst, the block SHALL stall with no write and no beat_cnt change, holding grant until fifo_full deasserts.
REQ-019 When req and s_valid are asserted by non-granted requesters, the block SHALL ignore them with no side effects.
REQ-020 When s_last and the BURST_LEN-th beat coincide, the block SHALL take a single transition to GAP.

Reset
REQ-021 rst high SHALL immediately force state=IDLE, grant=0, busy=0, beat_cnt=0, rr_ptr=0; s_ready and fifo_wr_en SHALL then be 0 combinationally.
REQ-022 Reset mid-burst SHALL drop the burst without completion; the first grant after release SHALL follow REQ-008/009 with rr_ptr=0.

Structure
REQ-023 State encoding constants (IDLE/BURST/GAP) SHALL reside in shared package fifo_ctrl_pkg, alongside a clog2-based width helper.
REQ-024 Round-robin selection SHALL be a sub-module rr_select (inputs req and rr_ptr, output one-hot and index), purely combinational.
REQ-025 The FIFO itself SHALL stay outside this block; the arbiter connects to its wr_en/din/full/wr_data_space ports in the wr_clk domain.

Verification
REQ-026 req=4'b1111, all s_valid=1, s_last=0, fifo_space=128 -> grants in order 0,1,2,3,0; each burst has 16 writes, then 1 GAP cycle and 1 IDLE cycle.
REQ-027 Requester 2 alone, s_last on beat 5 -> exactly 5 fifo_wr_en pulses, then beat_cnt=5, then GAP; next grant goes to 2 again if it still requests.
REQ-028 fifo_space=15 with req=4'b0001 -> grant stays 0 and no writes; raising space to 16 -> grant=4'b0001 one edge later.
REQ-029 fifo_full pulsed for 3 cycles at beat 8 -> 3 stall cycles, fifo_din held from s_data, total 16 writes, data order preserved.
REQ-030 rst asserted at beat 10 of requester 1, released, req=4'b0011 -> fifo_wr_en=0 during reset; next grant=4'b0001.
REQ-031 req[g] dropped with s_valid low at beat 4 -> GAP next edge, beat_cnt=4, and the following grant goes to the next requester.
